// File: rtl/tl_fc_pkg.sv
// Shared flow-control definitions: FSM state codes, DataFC scale codes and the scale-to-shift helper.
package tl_fc_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_INIT   = 2'b01;
   localparam logic [1:0] ST_ACTIVE = 2'b10;

   localparam logic [1:0] SCALE_X1_0 = 2'b00;
   localparam logic [1:0] SCALE_X1_1 = 2'b01;
   localparam logic [1:0] SCALE_X4   = 2'b10;
   localparam logic [1:0] SCALE_X16  = 2'b11;

   function automatic logic [2:0] fc_shift_amt(input logic [1:0] scale);
      case (scale)
         SCALE_X4:  fc_shift_amt = 3'd2;
         SCALE_X16: fc_shift_amt = 3'd4;
         default:   fc_shift_amt = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/tl_tx_fc_gate.sv
// Credit gate: passes when the request fits within the modular window ahead of consumed.
// Latency: combinational. Backpressure: ok=0 holds the requester off; no state.
module tl_tx_fc_gate #(
   parameter int CNT_W = 12,
   parameter int REQ_W = 9
) (
   input  logic             en,
   input  logic             infinite,
   input  logic [CNT_W-1:0] limit,
   input  logic [CNT_W-1:0] consumed,
   input  logic [REQ_W-1:0] req_creds,
   output logic             ok
);

   localparam logic [CNT_W-1:0] HALF = {1'b1, {(CNT_W-1){1'b0}}};

   logic [CNT_W-1:0] remain;

   // Window test is modular so counters may wrap freely
   assign remain = limit - (consumed + CNT_W'(req_creds));
   assign ok     = en & (infinite | (req_creds == '0) | (remain <= HALF));

endmodule

// File: rtl/tl_tx_fc_data.sv
// TX posted/completion data-credit tracker; optional blocked-request timeout via TL_TX_FC_DATA_TIMEOUT_EN.
// Latency: tx_data_ok is combinational; registers update on the next edge. Backpressure: tx_data_ok=0 stalls.
module tl_tx_fc_data
   import tl_fc_pkg::*;
#(
   parameter int DATA_FIELD_SIZE  = 12,
   parameter int PAYLOAD_IN_CREDS = 9,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dll_init,
   input  logic                        fc_valid,
   input  logic [11:0]                 fc_data_field,
   input  logic [1:0]                  dll_data_scale,
   input  logic                        tlp_req,
   input  logic [PAYLOAD_IN_CREDS-1:0] tlp_data_creds,
   input  logic                        tlp_consume,
   output logic                        tx_data_ok,
   output logic [DATA_FIELD_SIZE-1:0]  credit_limit,
   output logic [DATA_FIELD_SIZE-1:0]  credits_consumed,
   output logic                        fc_infinite
`ifdef TL_TX_FC_DATA_TIMEOUT_EN
   ,
   output logic                        fc_timeout
`endif
);

   logic [1:0]                 state;
   logic [1:0]                 state_nxt;
   logic                       init_loaded;
   logic                       enter_init;
   logic                       grant;
   logic [19:0]                field_shifted;
   logic [DATA_FIELD_SIZE-1:0] scaled;

   assign field_shifted = {8'd0, fc_data_field} << fc_shift_amt(dll_data_scale);
   assign scaled        = field_shifted[DATA_FIELD_SIZE-1:0];
   assign enter_init    = dll_init && (state != ST_INIT);
   assign grant         = tx_data_ok && tlp_consume;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = dll_init ? ST_INIT : ST_IDLE;
         ST_INIT:   state_nxt = dll_init ? ST_INIT : ST_ACTIVE;
         ST_ACTIVE: state_nxt = dll_init ? ST_INIT : ST_ACTIVE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Reset is folded into the enable so tx_data_ok is low for the whole reset cycle
   tl_tx_fc_gate #(
      .CNT_W (DATA_FIELD_SIZE),
      .REQ_W (PAYLOAD_IN_CREDS)
   ) u_gate (
      .en        ((state == ST_ACTIVE) && tlp_req && !rst),
      .infinite  (fc_infinite),
      .limit     (credit_limit),
      .consumed  (credits_consumed),
      .req_creds (tlp_data_creds),
      .ok        (tx_data_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         credit_limit     <= '0;
         credits_consumed <= '0;
         fc_infinite      <= 1'b0;
         init_loaded      <= 1'b0;
      end else begin
         state <= state_nxt;
         // Only the first InitFC of an init sequence counts; retransmissions are dropped
         if ((state == ST_INIT) && fc_valid && !init_loaded) begin
            credit_limit <= scaled;
            fc_infinite  <= (fc_data_field == 12'd0);
            init_loaded  <= 1'b1;
         end else if ((state == ST_ACTIVE) && fc_valid && !fc_infinite) begin
            credit_limit <= scaled;
         end
         if (grant && !fc_infinite)
            credits_consumed <= credits_consumed + DATA_FIELD_SIZE'(tlp_data_creds);
         if (enter_init) begin
            credits_consumed <= '0;
            fc_infinite      <= 1'b0;
            init_loaded      <= 1'b0;
         end
      end
   end

`ifdef TL_TX_FC_DATA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;
   logic          blocked;

   assign blocked = (state == ST_ACTIVE) && tlp_req && !tx_data_ok;

   always_ff @(posedge clk) begin
      if (rst || enter_init) begin
         to_cnt     <= '0;
         fc_timeout <= 1'b0;
      end else if (tx_data_ok || fc_valid) begin
         to_cnt <= '0;
      end else if (blocked && (to_cnt != TW'(TIMEOUT_CYCLES))) begin
         to_cnt <= to_cnt + TW'(1);
         if (to_cnt == TW'(TIMEOUT_CYCLES - 1))
            fc_timeout <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tl_tx_fc_data.sv
// Scoreboard bench for tl_tx_fc_data; timeout section active when TL_TX_FC_DATA_TIMEOUT_EN is defined.
module tb_tl_tx_fc_data;

   localparam int TO_CYC = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        dll_init;
   logic        fc_valid;
   logic [11:0] fc_data_field;
   logic [1:0]  dll_data_scale;
   logic        tlp_req;
   logic [8:0]  tlp_data_creds;
   logic        tlp_consume;

   logic        tx_data_ok, tx_data_ok16;
   logic [11:0] credit_limit, credits_consumed;
   logic [15:0] credit_limit16, credits_consumed16;
   logic        fc_infinite, fc_infinite16;
`ifdef TL_TX_FC_DATA_TIMEOUT_EN
   logic        fc_timeout, fc_timeout16;
`endif

   always #5 clk = ~clk;

   tl_tx_fc_data #(.DATA_FIELD_SIZE(12), .PAYLOAD_IN_CREDS(9), .TIMEOUT_CYCLES(TO_CYC)) u_dut (
      .clk(clk), .rst(rst), .dll_init(dll_init), .fc_valid(fc_valid),
      .fc_data_field(fc_data_field), .dll_data_scale(dll_data_scale),
      .tlp_req(tlp_req), .tlp_data_creds(tlp_data_creds), .tlp_consume(tlp_consume),
      .tx_data_ok(tx_data_ok), .credit_limit(credit_limit),
      .credits_consumed(credits_consumed), .fc_infinite(fc_infinite)
`ifdef TL_TX_FC_DATA_TIMEOUT_EN
      , .fc_timeout(fc_timeout)
`endif
   );

   tl_tx_fc_data #(.DATA_FIELD_SIZE(16), .PAYLOAD_IN_CREDS(9), .TIMEOUT_CYCLES(TO_CYC)) u_dut16 (
      .clk(clk), .rst(rst), .dll_init(dll_init), .fc_valid(fc_valid),
      .fc_data_field(fc_data_field), .dll_data_scale(dll_data_scale),
      .tlp_req(tlp_req), .tlp_data_creds(tlp_data_creds), .tlp_consume(tlp_consume),
      .tx_data_ok(tx_data_ok16), .credit_limit(credit_limit16),
      .credits_consumed(credits_consumed16), .fc_infinite(fc_infinite16)
`ifdef TL_TX_FC_DATA_TIMEOUT_EN
      , .fc_timeout(fc_timeout16)
`endif
   );

   typedef struct {
      string       tag;
      logic        ok;
      logic [11:0] lim;
      logic [11:0] cons;
      logic        inf;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: 0 idle, 1 init, 2 active
   int          m_state;
   logic [11:0] m_lim, m_cons;
   logic        m_inf, m_loaded;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [11:0] scale_val(input logic [11:0] fld, input logic [1:0] sc);
      logic [15:0] w;
      case (sc)
         2'b10:   w = {4'd0, fld} * 16'd4;
         2'b11:   w = {4'd0, fld} * 16'd16;
         default: w = {4'd0, fld};
      endcase
      return w[11:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({e.tag, ".ok"},   32'(tx_data_ok),       32'(e.ok));
         chk({e.tag, ".lim"},  32'(credit_limit),     32'(e.lim));
         chk({e.tag, ".cons"}, 32'(credits_consumed), 32'(e.cons));
         chk({e.tag, ".inf"},  32'(fc_infinite),      32'(e.inf));
      end
   end

   task automatic step(input string tag, input logic r, input logic di, input logic fv,
                       input logic [11:0] fld, input logic [1:0] sc, input logic rq,
                       input logic [8:0] cr, input logic cs);
      exp_t        e;
      logic        eok;
      logic [11:0] rem;
      int          ns;
      logic [11:0] nlim, ncons;
      logic        ninf, nld;
      rst = r; dll_init = di; fc_valid = fv; fc_data_field = fld; dll_data_scale = sc;
      tlp_req = rq; tlp_data_creds = cr; tlp_consume = cs;
      eok = 1'b0;
      if (!r && m_state == 2 && rq) begin
         rem = m_lim - m_cons - {3'd0, cr};
         eok = m_inf || (cr == 9'd0) || (rem <= 12'h800);
      end
      e.tag = tag; e.ok = eok; e.lim = m_lim; e.cons = m_cons; e.inf = m_inf;
      sb_q.push_back(e);
      nlim = m_lim; ncons = m_cons; ninf = m_inf; nld = m_loaded; ns = m_state;
      if (r) begin
         ns = 0; nlim = '0; ncons = '0; ninf = 1'b0; nld = 1'b0;
      end else begin
         if (m_state == 1 && fv && !m_loaded) begin
            nlim = scale_val(fld, sc); ninf = (fld == 12'd0); nld = 1'b1;
         end else if (m_state == 2 && fv && !m_inf) begin
            nlim = scale_val(fld, sc);
         end
         if (eok && cs && !m_inf) ncons = m_cons + {3'd0, cr};
         if (di && m_state != 1) begin
            ncons = '0; ninf = 1'b0; nld = 1'b0;
         end
         if (di) ns = 1;
         else if (m_state == 1) ns = 2;
      end
      @(posedge clk);
      #1;
      m_state = ns; m_lim = nlim; m_cons = ncons; m_inf = ninf; m_loaded = nld;
   endtask

   task automatic act(input string tag, input logic fv, input logic [11:0] fld, input logic [1:0] sc,
                      input logic rq, input logic [8:0] cr, input logic cs);
      step(tag, 1'b0, 1'b0, fv, fld, sc, rq, cr, cs);
   endtask

   task automatic ini(input string tag, input logic fv, input logic [11:0] fld, input logic [1:0] sc);
      step(tag, 1'b0, 1'b1, fv, fld, sc, 1'b1, 9'd1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; dll_init = 0; fc_valid = 0; fc_data_field = '0; dll_data_scale = '0;
      tlp_req = 0; tlp_data_creds = '0; tlp_consume = 0;
      m_state = 0; m_lim = '0; m_cons = '0; m_inf = 0; m_loaded = 0;
      repeat (2) @(posedge clk);
      #1;
      step("reset", 1'b1, 1'b0, 1'b0, 12'h0, 2'b00, 1'b1, 9'd0, 1'b0);
`ifdef TL_TX_FC_DATA_TIMEOUT_EN
      chk("rst_timeout", 32'(fc_timeout), 32'd0);
`endif
      act("idle_req", 1'b0, 12'h0, 2'b00, 1'b1, 9'd0, 1'b0);

      // init: first InitFC wins, retransmission ignored
      ini("init0", 1'b0, 12'h000, 2'b00);
      ini("init1", 1'b1, 12'h040, 2'b00);
      ini("init2", 1'b1, 12'h123, 2'b00);
      step("init_exit", 1'b0, 1'b0, 1'b0, 12'h0, 2'b00, 1'b1, 9'd1, 1'b0);
      chk("init_limit", 32'(credit_limit), 32'h040);
      chk("init_cons", 32'(credits_consumed), 32'h0);

      // exhaust and refill
      act("ex_c1", 1'b0, 12'h0, 2'b00, 1'b1, 9'h20, 1'b1);
      act("ex_c2", 1'b0, 12'h0, 2'b00, 1'b1, 9'h20, 1'b1);
      act("ex_blk", 1'b0, 12'h0, 2'b00, 1'b1, 9'h01, 1'b0);
      act("ex_ign", 1'b0, 12'h0, 2'b00, 1'b1, 9'h01, 1'b1);
      act("ex_zero", 1'b0, 12'h0, 2'b00, 1'b1, 9'h00, 1'b1);
      act("ex_noreq", 1'b0, 12'h0, 2'b00, 1'b0, 9'h01, 1'b0);
      act("ex_upd", 1'b1, 12'h050, 2'b00, 1'b1, 9'h01, 1'b0);
      act("ex_ok", 1'b0, 12'h0, 2'b00, 1'b1, 9'h01, 1'b0);
      chk("ex_cons", 32'(credits_consumed), 32'h040);

      // simultaneous update and consume
      act("sim_both", 1'b1, 12'h060, 2'b00, 1'b1, 9'h10, 1'b1);
      act("sim_fit", 1'b0, 12'h0, 2'b00, 1'b1, 9'h10, 1'b0);
      act("sim_over", 1'b0, 12'h0, 2'b00, 1'b1, 9'h11, 1'b0);

      // wrap: drive consumed to 0xFF8 in 0x1FF steps, limit tracking just ahead
      ini("wr_init0", 1'b0, 12'h0, 2'b00);
      ini("wr_init1", 1'b1, 12'h200, 2'b00);
      act("wr_exit", 1'b0, 12'h0, 2'b00, 1'b0, 9'h0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         act("wr_cons", 1'b0, 12'h0, 2'b00, 1'b1, 9'h1FF, 1'b1);
         act("wr_upd", 1'b1, 12'((k * 32'h1FF + 32'h200) & 32'hFFF), 2'b00, 1'b0, 9'h0, 1'b0);
      end
      chk("wr_pre", 32'(credits_consumed), 32'hFF8);
      act("wr_lim", 1'b1, 12'h008, 2'b00, 1'b0, 9'h0, 1'b0);
      act("wr_go", 1'b0, 12'h0, 2'b00, 1'b1, 9'h10, 1'b1);
      chk("wr_post", 32'(credits_consumed), 32'h008);

      // infinite credits
      ini("inf_init0", 1'b0, 12'h0, 2'b00);
      ini("inf_init1", 1'b1, 12'h000, 2'b00);
      act("inf_exit", 1'b0, 12'h0, 2'b00, 1'b0, 9'h0, 1'b0);
      chk("inf_flag", 32'(fc_infinite), 32'd1);
      act("inf_big", 1'b0, 12'h0, 2'b00, 1'b1, 9'h1FF, 1'b1);
      act("inf_upd", 1'b1, 12'h010, 2'b00, 1'b1, 9'h1FF, 1'b0);
      chk("inf_cons", 32'(credits_consumed), 32'h0);
      chk("inf_lim", 32'(credit_limit), 32'h0);

      // scaling, including the 16-bit counter instance
      ini("sc_init0", 1'b0, 12'h0, 2'b00);
      ini("sc_init1", 1'b1, 12'h010, 2'b11);
      act("sc_exit", 1'b0, 12'h0, 2'b00, 1'b0, 9'h0, 1'b0);
      chk("sc16_x16", 32'(credit_limit16), 32'h0100);
      chk("sc12_x16", 32'(credit_limit), 32'h100);
      act("sc_trunc", 1'b1, 12'h123, 2'b11, 1'b0, 9'h0, 1'b0);
      chk("sc16_trunc", 32'(credit_limit16), 32'h1230);
      act("sc_x4", 1'b1, 12'h040, 2'b10, 1'b0, 9'h0, 1'b0);
      chk("sc16_x4", 32'(credit_limit16), 32'h0100);
      act("sc_x1", 1'b1, 12'h007, 2'b01, 1'b1, 9'h4, 1'b1);

      // reset in the middle of activity
      step("mid_rst", 1'b1, 1'b0, 1'b1, 12'h100, 2'b00, 1'b1, 9'h1, 1'b1);
      act("post_rst", 1'b0, 12'h0, 2'b00, 1'b1, 9'h0, 1'b0);
      chk("rst_lim", 32'(credit_limit), 32'h0);
      chk("rst_ok", 32'(tx_data_ok), 32'd0);

`ifdef TL_TX_FC_DATA_TIMEOUT_EN
      ini("to_init0", 1'b0, 12'h0, 2'b00);
      ini("to_init1", 1'b1, 12'h001, 2'b00);
      act("to_exit", 1'b0, 12'h0, 2'b00, 1'b0, 9'h0, 1'b0);
      for (int i = 0; i < TO_CYC - 1; i++)
         act("to_blk", 1'b0, 12'h0, 2'b00, 1'b1, 9'h2, 1'b0);
      chk("to_before", 32'(fc_timeout), 32'd0);
      act("to_last", 1'b0, 12'h0, 2'b00, 1'b1, 9'h2, 1'b0);
      chk("to_set", 32'(fc_timeout), 32'd1);
      act("to_upd", 1'b1, 12'h001, 2'b00, 1'b1, 9'h2, 1'b0);
      chk("to_sticky", 32'(fc_timeout), 32'd1);
      ini("to_clr", 1'b0, 12'h0, 2'b00);
      chk("to_clear", 32'(fc_timeout), 32'd0);
`endif

      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
